// File: rtl/adc_spi_rx_if.sv
// adc_spi_rx_if -- signal bundle between the ADC serial receiver and its
// surroundings.
//   Enable    : permits new conversion starts
//   SDATA     : serial data from the ADC, MSB first
//   CS        : ADC chip select, active-low
//   SCLK      : ADC serial clock, idles high
//   Dato_ADC  : last complete 16-bit frame
//   Listo     : one-cycle pulse marking a new Dato_ADC value
//   Frame_err : one-cycle pulse with Listo when the protocol bits are nonzero
// master : receiver side (drives CS/SCLK and the result outputs)
// slave  : ADC/system side (drives Enable and SDATA)
interface adc_spi_rx_if;
  logic        Enable;
  logic        SDATA;
  logic        CS;
  logic        SCLK;
  logic [15:0] Dato_ADC;
  logic        Listo;
  logic        Frame_err;

  modport master (
    input  Enable,
    input  SDATA,
    output CS,
    output SCLK,
    output Dato_ADC,
    output Listo,
    output Frame_err
  );

  modport slave (
    output Enable,
    output SDATA,
    input  CS,
    input  SCLK,
    input  Dato_ADC,
    input  Listo,
    input  Frame_err
  );
endinterface

// File: rtl/adc_spi_rx.sv
// adc_spi_rx -- periodic 16-bit serial capture from an ADC.
// A free-running sample timer issues a tick every SAMPLE_PERIOD cycles; on a
// tick with Enable high the receiver lowers CS, clocks 16 bits in on SCLK
// rising edges and presents the frame on Dato_ADC with a Listo pulse.
// Ports:
//   CLK   : system clock, rising-edge
//   Reset : asynchronous active-low reset
//   bus   : adc_spi_rx_if.master (Enable, SDATA, CS, SCLK, Dato_ADC, Listo,
//           Frame_err)
//
// state | meaning
// IDLE  | CS high, SCLK high, waiting for an enabled tick
// SETUP | CS low, SCLK high for CLK_DIV cycles
// SHIFT | CS low, SCLK toggling; 16 rising edges sample SDATA
// DONE  | CS high, result loaded, Listo (and maybe Frame_err) high
module adc_spi_rx #(
  parameter int CLK_DIV       = 3,
  parameter int SAMPLE_PERIOD = 2500
) (
  input  logic         CLK,
  input  logic         Reset,
  adc_spi_rx_if.master bus
);

  localparam int CW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_PERIOD - 1);
  localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          tick;
  logic [DW-1:0] div_q, div_d;
  logic [4:0]    tog_q, tog_d;
  logic          sclk_q, sclk_d;
  logic          cs_q, cs_d;
  logic [15:0]   shift_q, shift_d;
  logic [15:0]   dato_q, dato_d;
  logic          listo_q, listo_d;
  logic          ferr_q, ferr_d;

  // Sample timer: free-running, independent of Enable and the FSM.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = (cnt_q == '0);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      tog_q   <= '0;
      sclk_q  <= 1'b1;
      cs_q    <= 1'b1;
      shift_q <= '0;
      dato_q  <= '0;
      listo_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tog_q   <= tog_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      shift_q <= shift_d;
      dato_q  <= dato_d;
      listo_q <= listo_d;
      ferr_q  <= ferr_d;
    end
  end

  // SHIFT spends 32 half-periods of CLK_DIV cycles each. SCLK enters SHIFT
  // high and its first toggle takes it low, so every period is low-then-high
  // and the 32nd toggle is the 16th rising edge. That edge samples the last
  // bit and leaves for DONE with SCLK high, giving a tick-to-Listo latency of
  // 33*CLK_DIV+1 cycles.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    tog_d   = tog_q;
    sclk_d  = sclk_q;
    shift_d = shift_q;
    dato_d  = dato_q;

    case (state_q)
      IDLE: begin
        sclk_d = 1'b1;
        if (tick && bus.Enable) begin
          state_d = SETUP;
          div_d   = DIV_LOAD;
        end
      end
      SETUP: begin
        if (div_q == '0) begin
          state_d = SHIFT;
          div_d   = DIV_LOAD;
          tog_d   = '0;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      SHIFT: begin
        if (div_q == '0) begin
          div_d  = DIV_LOAD;
          tog_d  = tog_q + 1'b1;
          sclk_d = ~sclk_q;
          // SCLK currently low means this toggle is a rising edge.
          if (!sclk_q) begin
            shift_d = {shift_q[14:0], bus.SDATA};
          end
          if (tog_q == 5'd31) begin
            state_d = DONE;
            dato_d  = {shift_q[14:0], bus.SDATA};
          end
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered outputs are derived from the next state so they line up
    // with the state they describe.
    cs_d    = !((state_d == SETUP) || (state_d == SHIFT));
    listo_d = (state_d == DONE);
    ferr_d  = (state_d == DONE) && (dato_d[15:12] != 4'b0000);
  end

  assign bus.CS        = cs_q;
  assign bus.SCLK      = sclk_q;
  assign bus.Dato_ADC  = dato_q;
  assign bus.Listo     = listo_q;
  assign bus.Frame_err = ferr_q;

endmodule

// File: tb/tb_adc_spi_rx.sv
// tb_adc_spi_rx -- self-checking bench for adc_spi_rx (CLK_DIV=2,
// SAMPLE_PERIOD=100). The reference model works in whole cycles counted from
// reset release: a tick is any cycle k with k%100==0; an enabled tick starts a
// frame, CS is low for cycles k+1..k+66 and Listo appears in cycle k+67.
module tb_adc_spi_rx;

  localparam int CLK_DIV       = 2;
  localparam int SAMPLE_PERIOD = 100;
  localparam int LAT           = 33 * CLK_DIV + 1;

  logic CLK   = 1'b0;
  logic Reset = 1'b1;

  adc_spi_rx_if bus ();

  adc_spi_rx #(
    .CLK_DIV       (CLK_DIV),
    .SAMPLE_PERIOD (SAMPLE_PERIOD)
  ) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  int          base     = 0;
  bit          active   = 1'b0;
  int          fstart   = 0;
  logic [15:0] exp_dato = 16'h0000;
  logic [15:0] frame_word = 16'h0000;
  logic [15:0] words[$];
  int          rises    = 0;
  logic [3:0]  adc_idx  = 4'd15;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ADC model: MSB presented when CS falls, next bit after each SCLK rise.
  initial begin
    logic cs_prev;
    logic sclk_prev;
    cs_prev   = 1'b1;
    sclk_prev = 1'b1;
    bus.SDATA = 1'b0;
    forever begin
      @(bus.CS or bus.SCLK);
      if (cs_prev && !bus.CS) begin
        adc_idx = 4'd15;
        rises   = 0;
      end else if (!sclk_prev && bus.SCLK) begin
        rises++;
        if (adc_idx != 4'd0) adc_idx = adc_idx - 4'd1;
      end
      cs_prev   = bus.CS;
      sclk_prev = bus.SCLK;
      bus.SDATA = frame_word[adc_idx];
    end
  end

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    if ($urandom_range(0, 1) == 1) w[15:12] = 4'b0000;
    return w;
  endfunction

  // One model cycle: drive Enable for the coming edge, then compare outputs.
  task automatic cycle(input logic en);
    int k;
    bit exp_cs_low;
    bit exp_listo;
    @(negedge CLK);
    bus.Enable = en;
    k = int'(cyc) - base;
    exp_listo  = active && (k == fstart + LAT);
    exp_cs_low = active && (k >= fstart + 1) && (k <= fstart + LAT - 1);
    if (exp_listo) exp_dato = frame_word;
    check_val("cs", 32'(bus.CS), 32'(!exp_cs_low));
    if (!exp_cs_low) check_val("sclk_idle", 32'(bus.SCLK), 32'd1);
    check_val("listo", 32'(bus.Listo), 32'(exp_listo));
    check_val("frame_err", 32'(bus.Frame_err),
              32'(exp_listo && (frame_word[15:12] != 4'b0000)));
    check_val("dato", 32'(bus.Dato_ADC), 32'(exp_dato));
    if (exp_listo) begin
      check_val("sclk_rises", 32'(rises), 32'd16);
      active = 1'b0;
    end
    if ((k % SAMPLE_PERIOD == 0) && en && !active) begin
      active = 1'b1;
      fstart = k;
      frame_word = (words.size() > 0) ? words.pop_front() : rand_word();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_cs"}, 32'(bus.CS), 32'd1);
    check_val({tag, "_sclk"}, 32'(bus.SCLK), 32'd1);
    check_val({tag, "_dato"}, 32'(bus.Dato_ADC), 32'd0);
    check_val({tag, "_listo"}, 32'(bus.Listo), 32'd0);
    check_val({tag, "_ferr"}, 32'(bus.Frame_err), 32'd0);
  endtask

  task automatic release_reset();
    @(posedge CLK);
    #2;
    Reset    = 1'b1;
    base     = int'(cyc);
    active   = 1'b0;
    exp_dato = 16'h0000;
  endtask

  initial begin
    int  n;
    logic en;
    bus.Enable = 1'b0;

    // Reset before any clock edge: outputs must already be at reset values.
    #1 Reset = 1'b0;
    #2 check_reset_outputs("rst_init");
    repeat (3) @(posedge CLK);

    words.push_back(16'h0ABC);
    words.push_back(16'h8FFF);
    release_reset();
    repeat (200) cycle(1'b1);

    // Abort a frame after its 8th SCLK rise.
    n = 0;
    do begin
      cycle(1'b1);
      n++;
    end while (!((bus.CS == 1'b0) && (rises >= 8)) && (n < 150));
    check_val("rises_before_rst", 32'(rises), 32'd8);
    #1 Reset = 1'b0;
    #1 check_reset_outputs("rst_mid");
    repeat (3) @(negedge CLK);
    check_reset_outputs("rst_hold");
    words.push_back(16'h0123);
    release_reset();
    repeat (200) cycle(1'b1);

    // Enable low across three ticks, then back on.
    repeat (300) cycle(1'b0);
    repeat (100) cycle(1'b1);

    // Enable dropped while shifting: frame completes, none follows.
    repeat (20) cycle(1'b1);
    repeat (180) cycle(1'b0);

    // Back-to-back frames.
    words.push_back(16'h0000);
    words.push_back(16'h0FFF);
    repeat (200) cycle(1'b1);

    // Random Enable activity with random ADC words.
    en = 1'b1;
    repeat (2000) begin
      if ($urandom_range(0, 39) == 0) en = ~en;
      cycle(en);
    end
    repeat (100) cycle(1'b1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/adc_spi_rx.md
ADC_SPI_RX -- requirements
Module: adc_spi_rx

Interface
REQ-001 Parameter CLK_DIV, default 3; CLK cycles per SCLK half-period, minimum 1.
REQ-002 Parameter SAMPLE_PERIOD, default 2500; CLK cycles between conversion starts, minimum 33*CLK_DIV+4.
REQ-003 CLK  input  1  system clock; all state changes on the rising edge.
REQ-004 Reset  input  1  reset, asynchronous and active-low; Reset=0 forces the reset state.
REQ-005 Enable  input  1  permits new conversion starts when high.
REQ-006 SDATA  input  1  ADC serial data, MSB first.
REQ-007 CS  output  1  ADC chip select, active-low, registered.
REQ-008 SCLK  output  1  ADC serial clock, idles high, registered.
REQ-009 Dato_ADC  output  16  last complete frame; [15:12] protocol bits, [11:0] offset-binary sample; feeds the downstream offset stage.
REQ-010 Listo  output  1  one-cycle pulse marking a new Dato_ADC value.
REQ-011 Frame_err  output  1  one-cycle pulse coincident with Listo when captured bits [15:12] != 4'b0000.

Function
REQ-012 Sample timer: the counter SHALL run 0..SAMPLE_PERIOD-1 and wrap; tick = (count==0); the counter runs regardless of Enable or FSM state.
REQ-013 FSM states: IDLE, SETUP, SHIFT, DONE.
REQ-014 IDLE: CS=1, SCLK=1; on tick with Enable=1 the FSM goes to SETUP; a tick with Enable=0 is ignored.
REQ-015 SETUP: CS=0, SCLK=1 for exactly CLK_DIV cycles, then SHIFT.
REQ-016 SHIFT: CS=0; SCLK toggles every CLK_DIV cycles, starting low, for 16 full periods (32*CLK_DIV cycles).
REQ-017 SHIFT sampling: on the CLK edge where SCLK goes 0->1, SDATA is shifted into a 16-bit register, MSB first.
REQ-018 SHIFT exit: the transition to DONE occurs on the CLK edge of the 16th SCLK rising edge, with SCLK left high.
REQ-019 DONE lasts one cycle: CS=1; Dato_ADC loads the shift register; Listo=1; Frame_err=1 if [15:12]!=0; the next state is IDLE.
REQ-020 Latency: Listo SHALL be high exactly 33*CLK_DIV+1 cycles after the tick cycle.
REQ-021 Dato_ADC holds its value between Listo pulses; Listo and Frame_err are 0 outside DONE.
REQ-022 Ticks arriving while the FSM is not in IDLE are ignored; a frame is never restarted or truncated by a tick.
REQ-023 Enable deasserted mid-frame: the current frame completes normally; no new frame starts.
REQ-024 SCLK count: exactly 16 rising edges per frame; no SCLK edges while CS=1.
REQ-025 CS high time: CS stays high at least SAMPLE_PERIOD-33*CLK_DIV-1 cycles between frames.

Reset
REQ-026 While Reset=0, outputs are forced immediately, without waiting for a CLK edge: CS=1, SCLK=1, Dato_ADC=16'h0000, Listo=0, Frame_err=0.
REQ-027 While Reset=0, internal state is forced: FSM=IDLE, sample counter=0, shift register=0.
REQ-028 Reset asserted mid-frame aborts the frame, and no Listo is produced for it.
REQ-029 After Reset is released, the first tick occurs on the first CLK edge with count==0.

Verification
REQ-030 CLK_DIV=2, SAMPLE_PERIOD=100, Enable=1; ADC model returns 16'h0ABC -> Dato_ADC=16'h0ABC, Listo pulse 67 cycles after tick, Frame_err=0, exactly 16 SCLK rising edges.
REQ-031 ADC model returns 16'h8FFF -> Dato_ADC=16'h8FFF with Frame_err=1 in the same cycle as Listo.
REQ-032 Reset driven low after the 8th SCLK rising edge -> CS=1, SCLK=1, Dato_ADC=0, Listo=0 without a CLK edge; after release, the next frame captures 16'h0123 correctly.
REQ-033 Enable=0 for 3 sample periods -> CS never falls and there is no Listo; Enable=1 -> a frame starts at the next tick.
REQ-034 Enable dropped during SHIFT -> the frame completes with a Listo pulse; no further CS falling edge follows.
REQ-035 Back-to-back frames 16'h0000 then 16'h0FFF -> Listo pulses exactly 100 cycles apart, and CS is high at least 34 cycles between frames.
